// File: rtl/uart_tx.sv
// uart_tx: serial transmitter. Each frame is a start bit, the data bits MSB-first,
// an optional even-parity bit and STOP_BITS stop bits. Words are loaded through
// a valid/ready handshake, and back-to-back frames are supported.
// Optional feature macro: UART_TX_PARITY_EN adds the even-parity bit after the data bits.
module uart_tx #(
  parameter int UART_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT    = 16,
  parameter int STOP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       tx_valid,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  output logic                       tx_ready,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(UART_DATA_WIDTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              baud_q, baud_d;
  logic [BW-1:0]              bit_q, bit_d;
  logic [UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       tx_d;
  logic                       baud_end;

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Even parity of the accepted word, captured at handshake
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_q <= 1'b0;
    end else if (state_q == S_IDLE && tx_valid) begin
      parity_q <= ^tx_data;
    end
  end
`endif

  assign tx_ready = (state_q == S_IDLE);
  assign tx_busy  = (state_q != S_IDLE);
  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, counters, shifter and next line value
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_done = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = {shift_q[UART_DATA_WIDTH-2:0], 1'b0};
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            tx_done = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line value follows the state being entered so tx changes with the state flop
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[UART_DATA_WIDTH-1];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, shifter and registered line output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames against a bit-slot reference model,
// on two instances (one and two stop bits) sharing clock and reset.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst;
  logic         v;
  logic [W-1:0] d;
  logic         sel;

  logic a_valid, a_ready, a_tx, a_busy, a_done;
  logic b_valid, b_ready, b_tx, b_busy, b_done;
  logic o_ready, o_tx, o_busy, o_done;

  assign a_valid = v & ~sel;
  assign b_valid = v & sel;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_tx    = sel ? b_tx    : a_tx;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;

  uart_tx #(.UART_DATA_WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .n_rst(n_rst), .tx_valid(a_valid), .tx_data(d),
    .tx_ready(a_ready), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done)
  );

  uart_tx #(.UART_DATA_WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .tx_valid(b_valid), .tx_data(d),
    .tx_ready(b_ready), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: value of the line in bit slot idx of a frame carrying data
  function automatic logic exp_bit(input logic [W-1:0] data, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= W) return data[W - idx];
    if (P == 1 && idx == W + 1) return ^data;
    return 1'b1;
  endfunction

  // Send one word and check every cycle of the frame plus the following idle cycle.
  // hold keeps tx_valid high with next_d for a back-to-back frame; poke_k >= 0 pulses
  // a stray request (8'h11) during cycle poke_k of the frame.
  task automatic frame(input logic [W-1:0] data, input bit use_b, input bit hold,
                       input logic [W-1:0] next_d, input int poke_k, input string name);
    int stops;
    int len;
    logic [W-1:0] rx;
    stops = use_b ? 2 : 1;
    len   = (1 + W + P + stops) * CPB;
    rx    = '0;
    sel = use_b;
    v   = 1'b1;
    d   = data;
    chk({name, " pre ready"}, o_ready, 1);
    chk({name, " pre tx"}, o_tx, 1);
    @(posedge clk);
    @(negedge clk);
    v = hold;
    d = hold ? next_d : W'($urandom);
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      if (!hold && poke_k >= 0) begin
        if (k == poke_k) begin
          v = 1'b1;
          d = 8'h11;
        end else if (k == poke_k + 1) begin
          v = 1'b0;
        end
      end
      chk($sformatf("%s tx c%0d", name, k + 1), o_tx, exp_bit(data, k / CPB));
      chk($sformatf("%s busy c%0d", name, k + 1), o_busy, 1);
      chk($sformatf("%s ready c%0d", name, k + 1), o_ready, 0);
      chk($sformatf("%s done c%0d", name, k + 1), o_done, (k == len - 1) ? 1 : 0);
      if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= W)
        rx = {rx[W-2:0], o_tx};
    end
    chk({name, " loopback"}, rx, data);
    @(negedge clk);
    chk({name, " post ready"}, o_ready, 1);
    chk({name, " post tx"}, o_tx, 1);
    chk({name, " post busy"}, o_busy, 0);
    chk({name, " post done"}, o_done, 0);
  endtask

  initial begin
    logic [W-1:0] data;
    logic [W-1:0] nd;
    bit           ub;
    bit           h;
    bit           pending;
    int           pk;

    n_rst = 1'b0;
    v     = 1'b0;
    d     = '0;
    sel   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst a tx", a_tx, 1);
    chk("rst a ready", a_ready, 1);
    chk("rst a busy", a_busy, 0);
    chk("rst a done", a_done, 0);
    chk("rst b tx", b_tx, 1);
    chk("rst b ready", b_ready, 1);
    chk("rst b busy", b_busy, 0);
    chk("rst b done", b_done, 0);
    n_rst = 1'b1;
    @(negedge clk);

    frame(8'hA5, 1'b0, 1'b0, 8'h00, -1, "a5");
    frame(8'h01, 1'b0, 1'b0, 8'h00, -1, "01");
    frame(8'h00, 1'b0, 1'b1, 8'hFF, -1, "b2b00");
    frame(8'hFF, 1'b0, 1'b0, 8'h00, -1, "b2bff");
    frame(8'h3C, 1'b1, 1'b0, 8'h00, -1, "stop2 3c");
    frame(8'hC6, 1'b0, 1'b0, 8'h00, CPB * 3 + 1, "ignored");

    // Reset in the middle of data bit 3
    sel  = 1'b0;
    v    = 1'b1;
    d    = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    v = 1'b0;
    for (int k = 1; k < CPB * 4 + 2; k++) @(negedge clk);
    chk("midrst pre tx", a_tx, exp_bit(8'hC3, 4));
    chk("midrst pre busy", a_busy, 1);
    n_rst = 1'b0;
    #1;
    chk("midrst tx", a_tx, 1);
    chk("midrst busy", a_busy, 0);
    chk("midrst ready", a_ready, 1);
    chk("midrst done", a_done, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    frame(8'h5A, 1'b0, 1'b0, 8'h00, -1, "after rst 5a");

    // Random frames, some back-to-back, some with stray requests
    pending = 1'b0;
    nd      = '0;
    ub      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pending) data = nd;
      else begin
        data = W'($urandom);
        ub   = 1'($urandom);
      end
      h  = (i < 19) && ($urandom_range(0, 3) == 0);
      nd = W'($urandom);
      pk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      frame(data, ub, h, nd, pk, $sformatf("rnd%0d", i));
      pending = h;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes a parallel data word onto the `tx` line as a start bit, data bits MSB-first, an optional even-parity bit and stop bit(s). It drives the same frame format that the receive-side shift register assembles. Bit timing comes from an internal baud counter. A valid/ready handshake lets the upstream logic load words, and back-to-back frames are supported.

## Interface
- `UART_DATA_WIDTH`, 8 (package value): data bits per frame.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  upstream has a word on `tx_data`.
- `tx_data`  in  UART_DATA_WIDTH  word to send; sampled only on handshake.
- `tx_ready`  out  1  transmitter can accept a word (IDLE only).
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  frame in progress (any state other than IDLE).
- `tx_done`  out  1  one-cycle pulse at the end of the final stop bit.

## Operation
- Handshake: a word is accepted in a cycle where `tx_valid && tx_ready` is true. `tx_data` is copied into the shift register in that cycle. `tx_data` is don't-care at all other times.
- States and transitions:
  - IDLE → START on handshake.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (macro on) or STOP, after UART_DATA_WIDTH bits.
  - PARITY → STOP after one bit time.
  - STOP → IDLE after STOP_BITS bit times.
- Line value per state:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = shift register MSB; the register shifts left by one (LSB filled with 0) at each bit boundary.
  - PARITY: `tx` = parity bit (see Configuration).
  - STOP: `tx`=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state entry. A bit boundary occurs when the count reaches CLKS_PER_BIT-1.
- Bit counter: width is $clog2(UART_DATA_WIDTH+1). It counts data bits in DATA and stop bits in STOP, and is cleared on each state entry.
- `tx_done` asserts in the last cycle of the last stop bit, together with the STOP → IDLE transition.
- `tx_valid` asserted while not in IDLE is ignored; no data is lost because `tx_ready`=0 during that time.
- Reset values, applied immediately on `n_rst` low (including mid-frame):
  - state IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - counters 0, shift register 0.
  - A frame in flight is abandoned. The line returns high asynchronously, and no partial stop bit is driven.

## Timing
- Handshake in cycle N: `tx` falls at the N+1 clock edge; `tx_busy`=1 and `tx_ready`=0 from N+1.
- Each bit is held for exactly CLKS_PER_BIT cycles.
- Frame length: (1 + UART_DATA_WIDTH + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with the macro and 0 without.
- Back-to-back: `tx_ready` rises in the cycle after `tx_done`. If `tx_valid` is held high, the next start bit begins one cycle after that. The inter-frame idle gap is therefore exactly one clock cycle beyond the stop bits.
- `tx` is driven from a flop, so it has no combinational path from any input.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists.
  - Parity bit = XOR of all data bits of the accepted word (even parity).
  - The parity value is computed and stored at handshake.
- `UART_TX_PARITY_EN` undefined: DATA goes directly to STOP. No parity logic or storage is synthesized.

## Test plan
- Single frame, CLKS_PER_BIT=4, STOP_BITS=1, no parity, `tx_data`=8'hA5.
  - Required `tx`: 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `tx_done` pulses at cycle 40 after the handshake; `tx_ready` returns at cycle 41.
- Back-to-back, `tx_valid` held high with 8'h00 then 8'hFF.
  - Two frames are sent with exactly one extra idle-high cycle between them.
  - A receive shifter looped back on `tx` captures 8'h00, then 8'hFF.
- Parity (macro on), CLKS_PER_BIT=4.
  - 8'hA5 → parity bit 0; 8'h01 → parity bit 1.
  - Frame length 44 cycles.
- STOP_BITS=2, 8'h3C → stop high for 8 cycles; `tx_done` only at the end of the second stop bit.
- Reset mid-frame: assert `n_rst` low during bit 3 of the DATA state.
  - `tx`=1, `tx_busy`=0, `tx_ready`=1 immediately (asynchronously).
  - After release, a new frame with 8'h5A transmits correctly.
- Ignored request: pulse `tx_valid` with 8'h11 mid-frame → no effect; the current frame completes unchanged.
